// File: rtl/opnd_deser80_pkg.sv
// Shared constants and state type for the 80-bit adder operand deserializer.
package opnd_deser80_pkg;

  localparam int ADD_WORD_W    = 16;
  localparam int ADD_NUM_WORDS = 5;
  localparam int ADD_W         = ADD_WORD_W * ADD_NUM_WORDS;
  localparam int CNT_W         = $clog2(ADD_NUM_WORDS);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/opnd_deser80_word_slot.sv
// One operand word position: an enabled A/B register pair cleared by async reset.
module opnd_deser80_word_slot
  import opnd_deser80_pkg::*;
#(
  parameter int WORD_W = ADD_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_a,
  input  logic [WORD_W-1:0] wr_b,
  output logic [WORD_W-1:0] slot_a,
  output logic [WORD_W-1:0] slot_b
);

  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] b_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (wr_en) begin
      a_reg <= wr_a;
      b_reg <= wr_b;
    end
  end

  assign slot_a = a_reg;
  assign slot_b = b_reg;

endmodule

// File: rtl/opnd_deser80.sv
// Collects five 16-bit A/B word pairs (LSB first) into one 80-bit operand set
// and holds it stable for the adder until it is accepted.
module opnd_deser80
  import opnd_deser80_pkg::*;
#(
  parameter int WORD_W    = ADD_WORD_W,
  parameter int NUM_WORDS = ADD_NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_a,
  input  logic [WORD_W-1:0]           in_b,
  input  logic                        in_cin,
  input  logic                        in_last,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_a,
  output logic [WORD_W*NUM_WORDS-1:0] out_b,
  output logic                        out_cin,
  output logic                        frame_err
);

  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            out_valid_reg;
  logic            frame_err_reg, frame_err_next;
  logic            cin_reg;

  logic            beat;
  logic            is_final;
  logic            set_done;
  logic            bad_frame;

  // A beat presented together with flush is dropped.
  assign beat      = in_valid && in_ready && !flush;
  assign is_final  = (cnt_reg == CW'(NUM_WORDS - 1));
  assign set_done  = beat && in_last && is_final;
  assign bad_frame = beat && (in_last != is_final);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (set_done)  state_next = HOLD;
      HOLD:    if (out_ready) state_next = COLLECT;
      default:                state_next = COLLECT;
    endcase
    if (flush) state_next = COLLECT;
  end

  always_comb begin
    in_ready = (state_reg == COLLECT);
  end

  always_comb begin
    cnt_next       = cnt_reg;
    frame_err_next = 1'b0;
    if (flush) begin
      cnt_next = '0;
    end else if (beat) begin
      if (bad_frame) begin
        cnt_next       = '0;
        frame_err_next = 1'b1;
      end else if (set_done) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (state_reg == HOLD && out_ready) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      cin_reg       <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      out_valid_reg <= (state_next == HOLD);
      frame_err_reg <= frame_err_next;
      if (beat && cnt_reg == '0) begin
        cin_reg <= in_cin;
      end
    end
  end

  // Each beat lands directly in its word slot; slots are never cleared except by reset.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
      logic slot_wr;
      assign slot_wr = beat && (cnt_reg == CW'(gi));

      opnd_deser80_word_slot #(
        .WORD_W (WORD_W)
      ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (slot_wr),
        .wr_a   (in_a),
        .wr_b   (in_b),
        .slot_a (out_a[gi*WORD_W +: WORD_W]),
        .slot_b (out_b[gi*WORD_W +: WORD_W])
      );
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_cin   = cin_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_opnd_deser80.sv
// Directed and randomized checks of opnd_deser80 against a set-level reference model.
module tb_opnd_deser80;

  localparam int W = 16;
  localparam int N = 5;
  localparam int OW = W * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_last = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_a;
  logic [OW-1:0] out_b;
  logic          out_cin;
  logic          frame_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a set is either being gathered (m_n words so far) or held.
  bit            m_hold;
  int            m_n;
  logic [OW-1:0] m_a;
  logic [OW-1:0] m_b;
  logic          m_cin;
  logic          m_ferr;

  opnd_deser80 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_cin   (out_cin),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_n    = 0;
    m_a    = '0;
    m_b    = '0;
    m_cin  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Applies the rules for one rising edge given the inputs present before it.
  task automatic model_edge(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic l, input logic fl, input logic ordy);
    m_ferr = 1'b0;
    if (fl) begin
      m_hold = 0;
      m_n    = 0;
    end else if (!m_hold && v) begin
      m_a[m_n*W +: W] = a;
      m_b[m_n*W +: W] = b;
      if (m_n == 0) m_cin = c;
      if (l != (m_n == N - 1)) begin
        m_ferr = 1'b1;
        m_n    = 0;
      end else if (l) begin
        m_hold = 1;
        m_n    = 0;
      end else begin
        m_n++;
      end
    end else if (m_hold && ordy) begin
      m_hold = 0;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", OW'(out_valid), OW'(m_hold));
    chk("out_a",     out_a,          m_a);
    chk("out_b",     out_b,          m_b);
    chk("out_cin",   OW'(out_cin),   OW'(m_cin));
    chk("frame_err", OW'(frame_err), OW'(m_ferr));
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic l, input logic fl, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    in_last   = l;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk("in_ready", OW'(in_ready), OW'(!m_hold));
    @(posedge clk);
    model_edge(v, a, b, c, l, fl, ordy);
    #1;
    check_outputs();
    $display("step v=%0b a=%h b=%h cin=%0b last=%0b flush=%0b ordy=%0b -> ov=%0b ferr=%0b",
             v, a, b, c, l, fl, ordy, out_valid, frame_err);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy);
  endtask

  // Full well-framed set; A words are a0+k, B words b0+k.
  task automatic send_set(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [W-1:0] inc,
                          input logic c, input logic ordy);
    for (int k = 0; k < N; k++) begin
      step(1'b1, W'(a0 + inc * W'(k)), W'(b0 + inc * W'(k)), (k == 0) ? c : ~c,
           (k == N - 1), 1'b0, ordy);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", OW'(out_valid), '0);
    chk("rst_out_a",     out_a,          '0);
    chk("rst_out_b",     out_b,          '0);
    chk("rst_out_cin",   OW'(out_cin),   '0);
    chk("rst_frame_err", OW'(frame_err), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    $display("reset applied and released");
  endtask

  initial begin
    model_reset();
    in_valid = 1'b0;
    #2;
    do_reset();

    // Basic set with out_ready held high.
    send_set(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    chk("basic_a", out_a, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    chk("basic_b", out_b, 80'h0001_0001_0001_0001_0001);
    chk("basic_valid", OW'(out_valid), OW'(1));
    idle(1'b1);
    chk("basic_valid_drop", OW'(out_valid), '0);
    idle(1'b1);

    // Backpressure: hold for 10 stalled cycles, then accept.
    send_set(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    chk("bp_a_held", out_a, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    idle(1'b1);
    chk("bp_released", OW'(in_ready), OW'(1));

    // Early last on beat 2, then a clean set of A words 1..5.
    for (int k = 0; k < 3; k++) step(1'b1, 16'hAAAA, 16'h5555, 1'b0, (k == 2), 1'b0, 1'b1);
    chk("early_ferr", OW'(frame_err), OW'(1));
    send_set(16'h0001, 16'h0010, 16'h0001, 1'b0, 1'b0);
    chk("early_next_a", out_a, 80'h0005_0004_0003_0002_0001);
    idle(1'b1);
    idle(1'b1);

    // Missing last on beat 4.
    for (int k = 0; k < N; k++) step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("miss_ferr", OW'(frame_err), OW'(1));
    idle(1'b1);
    send_set(16'h0100, 16'h0200, 16'h0011, 1'b1, 1'b1);
    idle(1'b1);

    // Flush during beat 3, then flush while holding.
    for (int k = 0; k < 3; k++) step(1'b1, 16'h7000, 16'h0700, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    send_set(16'h0A00, 16'h0B00, 16'h0101, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_hold_valid", OW'(out_valid), '0);
    send_set(16'h0C00, 16'h0D00, 16'h0003, 1'b1, 1'b1);
    idle(1'b1);

    // Reset while holding, then a full set.
    send_set(16'hCAFE, 16'hF00D, 16'h0001, 1'b1, 1'b0);
    idle(1'b0);
    do_reset();
    send_set(16'h1111, 16'h2222, 16'h1000, 1'b1, 1'b1);
    idle(1'b1);

    // Randomized traffic with occasional framing errors and flushes.
    for (int i = 0; i < 400; i++) begin
      logic rv, rl, rf, ro, rc;
      logic [W-1:0] ra, rb;
      rv = ($urandom_range(0, 9) < 8);
      rl = (m_n == N - 1) ^ ($urandom_range(0, 19) == 0);
      rf = ($urandom_range(0, 39) == 0);
      ro = ($urandom_range(0, 9) < 6);
      rc = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      step(rv, ra, rb, rc, rl, rf, ro);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opnd_deser80.md
Name: opnd_deser80

Overview:
- Upstream operand stage for the 80-bit ripple-carry adder.
- Accepts A/B operands as a stream of five 16-bit word pairs, LSB word first, with valid/ready handshake and framing. Assembles the full 80-bit A, 80-bit B and carry-in.
- Presents them to the adder as one registered, held-stable operand set with its own valid/ready handshake.

Parameters:
- WORD_W, 16, width of one input beat per operand; must equal the adder sub-block width.
- NUM_WORDS, 5, beats per operand set; output width = WORD_W*NUM_WORDS = 80.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_a  in  WORD_W  operand A word.
- in_b  in  WORD_W  operand B word.
- in_cin  in  1  carry-in; sampled on beat 0 only.
- in_last  in  1  marks final beat of an operand set.
- flush  in  1  synchronous clear of partial/held set.
- out_valid  out  1  assembled operand set valid.
- out_ready  in  1  downstream adder stage accepts the set.
- out_a  out  WORD_W*NUM_WORDS  assembled operand A.
- out_b  out  WORD_W*NUM_WORDS  assembled operand B.
- out_cin  out  1  assembled carry-in.
- frame_err  out  1  one-cycle pulse on framing violation.

Behaviour:
- Single clock, asynchronous active-low reset (rst_n).
- Reset values:
  - state = COLLECT, beat counter = 0.
  - out_valid = 0, out_a = 0, out_b = 0, out_cin = 0, frame_err = 0.
  - in_ready = 1 once rst_n is released.
- Beat transfer occurs when in_valid && in_ready at a rising edge.
- States:
  - COLLECT: in_ready = 1, out_valid = 0.
    - Beat k (counter value k) writes in_a into out_a[k*WORD_W +: WORD_W] and in_b into out_b likewise.
    - Beat 0 also captures in_cin into out_cin.
    - Counter increments after each beat.
  - COLLECT -> HOLD: on accepting beat NUM_WORDS-1 with in_last = 1. out_valid = 1 from the next cycle.
  - HOLD: in_ready = 0, out_valid = 1. out_a/out_b/out_cin are held bit-stable.
  - HOLD -> COLLECT: on out_valid && out_ready. Counter = 0, out_valid = 0 next cycle. Data registers keep their values; they are not cleared.
- Framing errors (COLLECT only):
  - in_last = 1 on beat k < NUM_WORDS-1: discard the partial set, counter = 0, frame_err = 1 for the next cycle, stay in COLLECT.
  - in_last = 0 on beat NUM_WORDS-1: same action (discard, counter = 0, frame_err pulse, stay in COLLECT).
  - The next beat is treated as beat 0.
- flush = 1, regardless of state:
  - Next cycle: state = COLLECT, counter = 0, out_valid = 0, frame_err = 0.
  - Any beat presented in the same cycle is dropped (in_ready is unaffected combinationally).
  - flush has priority over all other events.
- Latency: out_valid rises 1 cycle after the last beat is accepted.
- Minimum period per set is NUM_WORDS + 1 cycles: 5 beats plus 1 HOLD cycle when out_ready is held at 1.
- in_ready is a combinational decode of the registered state only. out_valid and the out_* data are registered.
- Downstream sees a stable set for as long as it stalls out_ready; no data changes while out_valid = 1.
- Async reset mid-set: the partial set is lost and outputs return to reset values immediately.

Decomposition:
- Shared package holds:
  - ADD_WORD_W = 16, ADD_NUM_WORDS = 5, ADD_W = 80.
  - State enum {COLLECT, HOLD}.
  - Counter width constant = clog2(ADD_NUM_WORDS).
- No sub-module required. Optional sub-module opnd_word_slot (one WORD_W-wide enabled register pair A/B) may be instantiated NUM_WORDS times via generate.

Test Plan:
- Basic set: beats (in_a, in_b) = (0xFFFF, 0x0001) x5, in_cin = 1 on beat 0, in_last on beat 4, out_ready = 1 -> out_a = 0xFFFF_FFFF_FFFF_FFFF_FFFF, out_b = 0x0001_0001_0001_0001_0001, out_cin = 1, out_valid for exactly 1 cycle, 1 cycle after beat 4.
- Backpressure: same set with out_ready = 0 for 10 cycles -> out_valid and data stable all 10 cycles, in_ready = 0 throughout; out_ready = 1 -> out_valid low next cycle, in_ready = 1.
- Early last: in_last = 1 on beat 2 -> frame_err pulse for 1 cycle, no out_valid. The following 5-beat set with A words 1,2,3,4,5 -> out_a = 0x0005_0004_0003_0002_0001.
- Missing last: 5 beats with in_last = 0 -> frame_err pulse, no out_valid, counter = 0.
- Flush: flush on beat 3 -> no out_valid. flush while in HOLD -> out_valid = 0 the next cycle, the next set assembles correctly.
- Reset: assert rst_n = 0 during HOLD -> out_valid, out_a, out_b, out_cin = 0 immediately; after release, in_ready = 1 and a full set assembles correctly.
